// File: rtl/triad_scheduler_pkg.sv
// Shared types and constants for the triad scheduler slice.
package triad_scheduler_pkg;

    localparam int ITER_W_DEF = 102;
    localparam int TS_W_DEF   = 24;
    localparam int DROP_W     = 8;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_WAIT_CLR = 2'd3
    } sched_state_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/triad_scheduler_if.sv
// Valid/ready frame channel from the scheduler to the host-link transmitter.
interface triad_scheduler_if
    import triad_scheduler_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF,
    parameter int TS_W   = TS_W_DEF
);
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_data;
    logic [ID_W-1:0]   out_triad_id;
    logic [TS_W-1:0]   out_ts;

    modport master (
        output out_valid, out_data, out_triad_id, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_triad_id, out_ts,
        output out_ready
    );
endinterface

// File: rtl/triad_scheduler_rr_arbiter.sv
// Combinational round-robin search: the first request after 'last', wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic [2:0]   grant,
    output logic         any_req
);
    logic found;

    // Walk offsets last+1 .. last+N and keep the first requester seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(last) + k) % N)) begin
                    grant = 3'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/triad_scheduler.sv
// Shares one output channel between N triad_managers, round-robin.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for any data_avl; grants, latches frame, starts send
// ST_SEND     | out_valid held; leaves on handshake or send timeout (drop)
// ST_RELEASE  | one-cycle reset_parser pulse to the served triad
// ST_WAIT_CLR | wait for that triad's data_avl to fall, bounded by timeout
module triad_scheduler
    import triad_scheduler_pkg::*;
#(
    parameter int N_TRIADS     = 4,
    parameter int ITER_W       = ITER_W_DEF,
    parameter int TS_W         = TS_W_DEF,
    parameter int SEND_TIMEOUT = 9600,
    parameter int CLR_TIMEOUT  = 16
) (
    input  logic                       clk_96MHz,
    input  logic                       reset_n,
    input  logic [TS_W-1:0]            sys_ts,
    input  logic [N_TRIADS-1:0]        triad_data_avl,
    input  logic [N_TRIADS*ITER_W-1:0] triad_iterations,
    output logic [N_TRIADS-1:0]        reset_parser,
    triad_scheduler_if.master          out_if,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       busy
);
    localparam int TMR_MAX = (SEND_TIMEOUT > CLR_TIMEOUT) ? SEND_TIMEOUT : CLR_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SEND_LOAD = TMR_W'(SEND_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CLR_LOAD  = TMR_W'(CLR_TIMEOUT - 1);

    sched_state_t          state;
    logic [2:0]            rr_ptr;
    logic [TMR_W-1:0]      tmr;
    logic [2:0]            grant;
    logic                  any_req;
    logic [ITER_W-1:0]     grant_data;
    logic [N_TRIADS-1:0]   id_onehot;
    logic                  cur_avl;

    rr_arbiter #(.N(N_TRIADS)) u_arb (
        .req     (triad_data_avl),
        .last    (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // Mux the granted word and decode the latched id without wide variable indexing.
    always_comb begin
        id_onehot  = '0;
        grant_data = '0;
        for (int i = 0; i < N_TRIADS; i++) begin
            id_onehot[i] = (out_if.out_triad_id == 3'(i));
            if (grant == 3'(i)) begin
                grant_data = triad_iterations[i*ITER_W +: ITER_W];
            end
        end
    end

    assign cur_avl = |(triad_data_avl & id_onehot);

    // Scheduler FSM; timer is a down-counter reused by SEND and WAIT_CLR.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            rr_ptr              <= '0;
            tmr                 <= '0;
            reset_parser        <= '0;
            out_if.out_valid    <= 1'b0;
            out_if.out_data     <= '0;
            out_if.out_triad_id <= '0;
            out_if.out_ts       <= '0;
            drop_count          <= '0;
            busy                <= 1'b0;
        end else begin
            reset_parser <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        out_if.out_valid    <= 1'b1;
                        out_if.out_data     <= grant_data;
                        out_if.out_triad_id <= grant;
                        out_if.out_ts       <= sys_ts;
                        rr_ptr              <= grant;
                        tmr                 <= SEND_LOAD;
                        busy                <= 1'b1;
                        state               <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Handshake takes priority over a coincident timeout.
                    if (out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        reset_parser     <= id_onehot;
                        state            <= ST_RELEASE;
                    end else if (tmr == '0) begin
                        out_if.out_valid <= 1'b0;
                        reset_parser     <= id_onehot;
                        drop_count       <= sat_inc(drop_count);
                        state            <= ST_RELEASE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    tmr   <= CLR_LOAD;
                    state <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    if (!cur_avl || tmr == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_triad_scheduler.sv
// Directed and randomized bench for triad_scheduler with a frame-level model.
module tb_triad_scheduler;
    import triad_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int IW = 102;
    localparam int TW = 24;
    localparam int ST = 64;
    localparam int CT = 16;

    logic clk_96MHz = 1'b0;
    always #5 clk_96MHz = ~clk_96MHz;

    logic              reset_n;
    logic [TW-1:0]     sys_ts;
    logic [N-1:0]      triad_data_avl;
    logic [N*IW-1:0]   triad_iterations;
    logic [N-1:0]      reset_parser;
    logic [7:0]        drop_count;
    logic              busy;

    triad_scheduler_if #(.ITER_W(IW), .TS_W(TW)) tif ();

    triad_scheduler #(
        .N_TRIADS(N), .ITER_W(IW), .TS_W(TW),
        .SEND_TIMEOUT(ST), .CLR_TIMEOUT(CT)
    ) dut (
        .clk_96MHz        (clk_96MHz),
        .reset_n          (reset_n),
        .sys_ts           (sys_ts),
        .triad_data_avl   (triad_data_avl),
        .triad_iterations (triad_iterations),
        .reset_parser     (reset_parser),
        .out_if           (tif),
        .drop_count       (drop_count),
        .busy             (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [IW-1:0] iter_m [N];
    int clr_delay [N];
    int clr_cnt   [N];

    int exp_rr, exp_drops, valid_age, xfers, valid_cycles;
    logic [2:0]    exp_id;
    logic [TW-1:0] exp_ts;
    logic [IW-1:0] exp_data;
    int grants_q[$];
    int pulses_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req_v);
        n_assert++;
        assert (obs === req_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req_v);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [IW-1:0] rnd_iter();
        return IW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic drive_iters();
        for (int i = 0; i < N; i++) triad_iterations[i*IW +: IW] = iter_m[i];
    endtask

    task automatic model_reset();
        exp_rr = 0; exp_drops = 0; valid_age = 0;
    endtask

    // One clock: snapshot inputs, advance, check the frame model, run the triad models.
    task automatic tick();
        logic [N-1:0]    p_avl;
        logic [N*IW-1:0] p_iters;
        logic [TW-1:0]   p_ts;
        logic            p_valid, p_ready, p_busy, p_rst;
        logic [N-1:0]    exp_pulse;
        int              g;
        p_avl = triad_data_avl; p_iters = triad_iterations; p_ts = sys_ts;
        p_valid = tif.out_valid; p_ready = tif.out_ready; p_busy = busy; p_rst = reset_n;
        @(posedge clk_96MHz);
        #1;
        exp_pulse = '0;
        if (p_rst && reset_n) begin
            if (tif.out_valid) valid_cycles++;
            if (p_valid) begin
                valid_age++;
                if (p_ready) begin
                    chk("handshake_valid_low", tif.out_valid, 0);
                    xfers++;
                    exp_pulse = N'(1) << exp_id;
                end else if (valid_age == ST) begin
                    chk("timeout_valid_low", tif.out_valid, 0);
                    if (exp_drops < 255) exp_drops++;
                    exp_pulse = N'(1) << exp_id;
                end else begin
                    chk("frame_hold", {tif.out_valid, tif.out_triad_id, tif.out_ts, tif.out_data},
                        {1'b1, exp_id, exp_ts, exp_data});
                end
            end else if (tif.out_valid || (!p_busy && p_avl != '0)) begin
                g = rr_pick(p_avl, exp_rr);
                chk("grant_from_idle", {p_busy, tif.out_valid, g >= 0}, {1'b0, 1'b1, 1'b1});
                if (g >= 0) begin
                    chk("grant_frame", {tif.out_triad_id, tif.out_ts, tif.out_data},
                        {3'(g), p_ts, p_iters[g*IW +: IW]});
                    exp_rr = g; exp_id = 3'(g); exp_ts = p_ts; exp_data = p_iters[g*IW +: IW];
                    valid_age = 0;
                    grants_q.push_back(g);
                end
            end
            chk("reset_parser", reset_parser, exp_pulse);
            chk("drop_count", drop_count, exp_drops);
            for (int i = 0; i < N; i++) if (reset_parser[i]) pulses_q.push_back(i);
        end
        for (int i = 0; i < N; i++) begin
            if (clr_cnt[i] > 0) begin
                clr_cnt[i]--;
                if (clr_cnt[i] == 0) begin
                    triad_data_avl[i] = 1'b0;
                    clr_cnt[i] = -1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (reset_parser[i] && clr_delay[i] >= 0) begin
                if (clr_delay[i] == 0) triad_data_avl[i] = 1'b0;
                else clr_cnt[i] = clr_delay[i];
            end
        end
        sys_ts = TW'($urandom);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (grants_q.size() < n && t < budget) begin tick(); t++; end
        chk("wait_grants", grants_q.size() >= n, 1);
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while ((busy || tif.out_valid || triad_data_avl != '0) && t < budget) begin tick(); t++; end
        chk("wait_quiet", {busy, tif.out_valid, triad_data_avl}, '0);
    endtask

    task automatic wait_pulse(input int budget);
        int t = 0;
        while (reset_parser == '0 && t < budget) begin tick(); t++; end
        chk("wait_pulse", reset_parser != '0, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n0;
        bit rer;
        logic [IW-1:0] saved;

        reset_n = 1'b0; tif.out_ready = 1'b0; triad_data_avl = '0; sys_ts = '0;
        for (int i = 0; i < N; i++) begin iter_m[i] = '0; clr_delay[i] = 0; clr_cnt[i] = -1; end
        drive_iters(); model_reset(); xfers = 0; valid_cycles = 0;
        repeat (3) tick();
        chk("rst_valid", tif.out_valid, 0);
        chk("rst_reset_parser", reset_parser, 0);
        chk("rst_data", tif.out_data, 0);
        chk("rst_id", tif.out_triad_id, 0);
        chk("rst_ts", tif.out_ts, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick(); tick();

        // Single request on triad 2
        iter_m[2] = 102'h123; drive_iters(); clr_delay[2] = 2;
        sys_ts = 24'h00ABCD; tif.out_ready = 1'b1; triad_data_avl[2] = 1'b1;
        tick();
        chk("single_valid", tif.out_valid, 1);
        chk("single_data", tif.out_data, 102'h123);
        chk("single_id", tif.out_triad_id, 2);
        chk("single_ts", tif.out_ts, 24'h00ABCD);
        tick();
        chk("single_release", reset_parser, 4'b0100);
        wait_quiet(40);
        chk("single_busy_low", busy, 0);

        // Lone triad 3 so the next full sweep starts at triad 0
        iter_m[3] = rnd_iter(); drive_iters(); clr_delay[3] = 1; triad_data_avl[3] = 1'b1;
        wait_grants(2, 10);
        wait_quiet(40);

        // Simultaneous requests, triad 0 re-raises once
        grants_q.delete(); pulses_q.delete();
        for (int i = 0; i < N; i++) begin iter_m[i] = rnd_iter(); clr_delay[i] = 3; end
        drive_iters(); triad_data_avl = 4'b1111;
        t = 0; rer = 1'b0;
        while (grants_q.size() < 5 && t < 500) begin
            tick(); t++;
            if (!rer && grants_q.size() >= 1 && !triad_data_avl[0] && clr_cnt[0] < 0) begin
                iter_m[0] = rnd_iter(); drive_iters(); triad_data_avl[0] = 1'b1; rer = 1'b1;
            end
        end
        chk("sim_grant_count", grants_q.size(), 5);
        if (grants_q.size() >= 5)
            for (int k = 0; k < 5; k++) chk("sim_grant_order", grants_q[k], k % N);
        wait_quiet(200);
        chk("sim_pulse_count", pulses_q.size(), 5);
        if (pulses_q.size() >= 5)
            for (int k = 0; k < 5; k++) chk("sim_pulse_order", pulses_q[k], k % N);

        // Backpressure: ready low for 50 valid cycles, high on the 51st
        tif.out_ready = 1'b0; n0 = xfers; grants_q.delete(); valid_cycles = 0;
        iter_m[1] = rnd_iter(); drive_iters(); clr_delay[1] = 1; triad_data_avl[1] = 1'b1;
        wait_grants(1, 10);
        repeat (50) tick();
        tif.out_ready = 1'b1;
        tick();
        chk("bp_valid_cycles", valid_cycles, 51);
        chk("bp_transfers", xfers - n0, 1);
        chk("bp_drop_count", drop_count, 0);
        wait_quiet(40);

        // Send timeout, then saturation of drop_count
        tif.out_ready = 1'b0; clr_delay[0] = 0; grants_q.delete(); valid_cycles = 0;
        triad_data_avl[0] = 1'b1;
        wait_grants(1, 10);
        wait_pulse(ST + 5);
        chk("to_valid_cycles", valid_cycles, ST);
        chk("to_pulse", reset_parser, 4'b0001);
        chk("to_drop_one", drop_count, 1);
        wait_quiet(40);
        for (int r = 0; r < 299; r++) begin
            triad_data_avl[0] = 1'b1;
            wait_grants(grants_q.size() + 1, 10);
            wait_quiet(ST + 40);
        end
        chk("to_drop_saturated", drop_count, 255);

        // Stuck data_avl on triad 1 with triad 3 pending
        tif.out_ready = 1'b1; clr_delay[1] = -1; clr_delay[3] = 1; grants_q.delete();
        triad_data_avl[1] = 1'b1;
        wait_grants(1, 10);
        iter_m[3] = rnd_iter(); drive_iters(); triad_data_avl[3] = 1'b1;
        wait_pulse(10);
        t = 0;
        while (busy && t < 100) begin tick(); t++; end
        chk("stuck_clr_timeout", t, CT + 1);
        wait_grants(2, 10);
        chk("stuck_next_grant", grants_q[grants_q.size()-1], 3);
        clr_delay[1] = 2;
        wait_grants(3, 100);
        chk("stuck_regrant", grants_q[grants_q.size()-1], 1);
        wait_quiet(100);

        // Reset during SEND
        tif.out_ready = 1'b0; iter_m[2] = rnd_iter(); saved = iter_m[2]; drive_iters();
        clr_delay[2] = 1; grants_q.delete(); triad_data_avl[2] = 1'b1;
        wait_grants(1, 10);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", tif.out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pulse", reset_parser, 0);
        model_reset();
        repeat (2) tick();
        chk("rst_mid_no_pulse", reset_parser, 0);
        reset_n = 1'b1; tif.out_ready = 1'b1; grants_q.delete();
        wait_grants(1, 10);
        chk("rst_reserve_id", tif.out_triad_id, 2);
        chk("rst_reserve_data", tif.out_data, saved);
        wait_quiet(40);

        // Randomized traffic
        grants_q.delete(); pulses_q.delete();
        for (int c = 0; c < 3000; c++) begin
            tif.out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!triad_data_avl[i] && clr_cnt[i] < 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        iter_m[i] = rnd_iter();
                        clr_delay[i] = $urandom_range(0, 5);
                        triad_data_avl[i] = 1'b1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        iter_m[i] = rnd_iter();
                    end
                end
            end
            drive_iters();
            tick();
        end
        tif.out_ready = 1'b1;
        wait_quiet(500);
        chk("rnd_activity", grants_q.size() > 20, 1);
        chk("rnd_pulse_per_grant", pulses_q.size(), grants_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
